// File: rtl/als_error_monitor.sv
// als_error_monitor: compares exact vs approximate circuit outputs and
// accumulates error statistics over a run of n_samples sample pairs.
// Optional feature: define ALS_ERROR_MONITOR_HAMMING_EN to build the
// popcount stage and ham_sum accumulator; otherwise ham_sum reads 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_RUN   | accepting sample pairs until the target count is reached
// S_DRAIN | two cycles letting the two-stage pipeline empty
// S_DONE  | statistics final and held until the next accepted start
module als_error_monitor #(
  parameter int DW    = 32,
  parameter int CH    = 2,
  parameter int CNT_W = 32,
  parameter int ACC_W = 96
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    n_samples,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [CH*DW-1:0]    s_exact,
  input  logic [CH*DW-1:0]    s_approx,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    err_count,
  output logic [ACC_W-1:0]    ed_sum,
  output logic [CH*DW-1:0]    ed_max,
  output logic [ACC_W-1:0]    ham_sum,
  output logic                sat
);

  localparam int W  = CH * DW;
  localparam int PW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_start_acc;
  logic             w_xfer;
  logic [CNT_W-1:0] r_remaining;
  logic             r_drain_cnt;

  logic             r_p1_valid;
  logic [W-1:0]     r_p1_ed;
  logic             r_p1_mis;
  logic [W-1:0]     w_ed;

  logic [CNT_W-1:0] r_err_count;
  logic [ACC_W-1:0] r_ed_sum;
  logic [W-1:0]     r_ed_max;
  logic             r_sat;
  logic [ACC_W:0]   w_ed_add;
  logic             w_ham_ovf;

  assign w_xfer   = s_valid && s_ready;
  assign w_ed     = (s_exact >= s_approx) ? (s_exact - s_approx) : (s_approx - s_exact);
  assign w_ed_add = {1'b0, r_ed_sum} + (ACC_W + 1)'(r_p1_ed);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    s_ready     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (n_samples == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        s_ready = (r_remaining != '0);
        if (s_valid && (r_remaining == CNT_W'(1))) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_drain_cnt == 1'b0) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Samples still to accept (down-counter, terminal count at 1 on transfer).
  always_ff @(posedge clk) begin
    if (rst)              r_remaining <= '0;
    else if (w_start_acc) r_remaining <= n_samples;
    else if (w_xfer)      r_remaining <= r_remaining - CNT_W'(1);
  end

  // Drain timer: reloads outside DRAIN, counts 1 -> 0 inside it.
  always_ff @(posedge clk) begin
    if (rst)                     r_drain_cnt <= 1'b1;
    else if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt - 1'b1;
    else                         r_drain_cnt <= 1'b1;
  end

  // Stage 1: register distance and mismatch of the accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1_valid <= 1'b0;
      r_p1_ed    <= '0;
      r_p1_mis   <= 1'b0;
    end else begin
      r_p1_valid <= w_xfer;
      r_p1_ed    <= w_ed;
      r_p1_mis   <= (s_exact != s_approx);
    end
  end

  // Stage 2: fold stage-1 results into the run statistics.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_err_count <= '0;
      r_ed_sum    <= '0;
      r_ed_max    <= '0;
    end else if (r_p1_valid) begin
      r_err_count <= r_err_count + CNT_W'(r_p1_mis);
      r_ed_sum    <= w_ed_add[ACC_W] ? '1 : w_ed_add[ACC_W-1:0];
      if (r_p1_ed > r_ed_max) r_ed_max <= r_p1_ed;
    end
  end

  // Sticky saturation flag, cleared only by reset or an accepted start.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc)                             r_sat <= 1'b0;
    else if (r_p1_valid && (w_ed_add[ACC_W] || w_ham_ovf)) r_sat <= 1'b1;
  end

`ifdef ALS_ERROR_MONITOR_HAMMING_EN
  logic [W-1:0]     w_diff;
  logic [PW-1:0]    w_pop;
  logic [PW-1:0]    r_p1_pop;
  logic [ACC_W-1:0] r_ham_sum;
  logic [ACC_W:0]   w_ham_add;

  assign w_diff    = s_exact ^ s_approx;
  assign w_ham_add = {1'b0, r_ham_sum} + (ACC_W + 1)'(r_p1_pop);
  assign w_ham_ovf = w_ham_add[ACC_W];
  assign ham_sum   = r_ham_sum;

  // Count differing bits of the incoming pair.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < W; i++) w_pop = w_pop + PW'(w_diff[i]);
  end

  // Stage 1 popcount register.
  always_ff @(posedge clk) begin
    if (rst) r_p1_pop <= '0;
    else     r_p1_pop <= w_pop;
  end

  // Stage 2 saturating Hamming accumulator.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) r_ham_sum <= '0;
    else if (r_p1_valid)    r_ham_sum <= w_ham_ovf ? '1 : w_ham_add[ACC_W-1:0];
  end
`else
  assign w_ham_ovf = 1'b0;
  assign ham_sum   = '0;
`endif

  assign err_count = r_err_count;
  assign ed_sum    = r_ed_sum;
  assign ed_max    = r_ed_max;
  assign sat       = r_sat;

endmodule
